rv32i_fetch_unit: RTL

- Instruction fetch stage directly upstream of the RV32I op decoder.
- Owns the PC, issues word requests to instruction memory over a req/gnt + rvalid bus, and buffers returned words in a small in-order prefetch FIFO.
- Presents {instr, pc} to decode with a valid/ready handshake, and splits out the op, fun3 and fun7 fields the decoder consumes.
- Accepts redirects from the jump/branch resolution path: flushes the buffer and discards in-flight responses.

---
 rtl/rv32i_pkg.sv | 34 +++
 rtl/rv32i_sync_fifo.sv | 60 ++++++
 rtl/rv32i_fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: widths, instruction field positions, opcodes and
// the fetch-buffer entry layout used by the fetch unit and the op decoder.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam int unsigned OP_LSB   = 0;
    localparam int unsigned OP_MSB   = 6;
    localparam int unsigned FUN3_LSB = 12;
    localparam int unsigned FUN3_MSB = 14;
    localparam int unsigned FUN7_LSB = 25;
    localparam int unsigned FUN7_MSB = 31;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/rv32i_sync_fifo.sv
// Small synchronous FIFO with flush; the head entry is read straight from the
// storage registers. A push into a full FIFO is accepted only alongside a pop.
module rv32i_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch: PC, imem req/gnt/rvalid, in-order prefetch buffer
// and redirect flush. Define RV32I_FETCH_BYPASS_EN for same-cycle rvalid bypass.
module rv32i_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic [6:0]      op_o,
    output logic [2:0]      fun3_o,
    output logic [6:0]      fun7_o
);

    localparam int unsigned FW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = FW + 1;

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   inflight;
    logic [FW-1:0]   occ;
    logic [FW-1:0]   outstanding;
    logic            fifo_full, fifo_empty;
    logic            tag_full, tag_empty;
    logic [XLEN-1:0] tag_pc;
    fetch_entry_t    head, push_entry, out_entry;
    logic            grant, rsp_live, rsp_take, bypass, push, pop;

    // The tag queue holds exactly the PCs of live outstanding requests, so its
    // occupancy doubles as the outstanding count.
    assign inflight    = CW'(occ) + CW'(outstanding) + discard;
    assign imem_req_o  = rst_n_i && !fifo_full && !tag_full && (inflight < CW'(DEPTH));
    assign imem_addr_o = pc;
    assign grant       = imem_req_o && imem_gnt_i;
    assign rsp_live    = imem_rvalid_i && (!tag_empty || discard != '0);
    assign rsp_take    = imem_rvalid_i && !tag_empty && (discard == '0);
    assign push_entry  = '{pc: tag_pc, instr: imem_rdata_i};

`ifdef RV32I_FETCH_BYPASS_EN
    assign bypass    = rsp_take && fifo_empty && !redirect_i;
    assign out_entry = bypass ? push_entry : head;
`else
    assign bypass    = 1'b0;
    assign out_entry = head;
`endif

    assign push          = rsp_take && !redirect_i && !(bypass && instr_ready_i);
    assign pop           = instr_ready_i && !fifo_empty && !redirect_i;
    assign instr_valid_o = !fifo_empty || bypass;
    assign instr_o       = out_entry.instr;
    assign instr_pc_o    = out_entry.pc;
    assign op_o          = instr_o[OP_MSB:OP_LSB];
    assign fun3_o        = instr_o[FUN3_MSB:FUN3_LSB];
    assign fun7_o        = instr_o[FUN7_MSB:FUN7_LSB];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc      <= RESET_PC & ~32'h3;
            discard <= '0;
        end else if (redirect_i) begin
            // Everything in flight at the redirect, including this cycle's grant,
            // must drain as discarded responses.
            pc      <= redirect_pc_i & ~32'h3;
            discard <= discard + CW'(outstanding) + CW'(grant) - CW'(rsp_live);
        end else begin
            if (grant) begin
                pc <= pc + 32'd4;
            end
            if (imem_rvalid_i && discard != '0) begin
                discard <= discard - 1'b1;
            end
        end
    end

    rv32i_sync_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occ)
    );

    rv32i_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_queue (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .push  (grant),
        .pop   (rsp_take),
        .flush (redirect_i),
        .wdata (pc),
        .rdata (tag_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (outstanding)
    );

endmodule
